rr_arbiter_quantum: RTL and testbench
=====================================

// Module: rr_arbiter_quantum
// PURPOSE
// - Round-robin arbiter with per-requester burst quantum and valid/ready handshake to the granted resource.
// - Holds a grant for up to quantum[i]+1 accepted beats before rotating; releases early if req drops.
// - Sits between warp issue queues and shared execution/memory ports.
// - Registered grant, one-cycle arbitration latency, no bubble on handover.
// PARAMETERS
// - WIDTH   16  number of requesters (>=2, any integer; pointer wraps WIDTH-1 -> 0)
// - QW      4   width of each per-requester quantum field
// - COUNTW  $clog2(WIDTH)  localparam, width of grant index
// PORTS
// - clk        in   1           clock
// - reset      in   1           synchronous, active-low reset
// - req        in   WIDTH       request vector, level-sensitive
// - quantum    in   WIDTH*QW    flat per-requester quantum, field i = [i*QW +: QW]; beats allowed = value+1
// - ready      in   1           downstream accepts a beat this cycle
// - hi_pri     in   WIDTH       high-priority class flags (only with ARB_PRIORITY_EN)
// - grant      out  COUNTW      index of current owner
// - grant_oh   out  WIDTH       one-hot owner, qualified by grant_valid (all zero when invalid)
// - grant_valid out 1           owner holds grant and req[owner]==1
// - beat_last  out  1           current accepted beat is the owner's final beat of the quantum
// - empty      out  1           ~grant_valid
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE, ptr=0, owner=0, beats=0; all outputs 0 except empty=1. Reset overrides everything, including mid-burst.
// - ptr is the search start; pick = first i with req[i]==1, scanning ptr, ptr+1, ... wrapping modulo WIDTH.
// - IDLE: if |req, register owner=pick, beats=0, go GRANT; else stay. Grant visible the cycle after the request (1-cycle latency).
// - GRANT: grant_valid = req[owner]. A beat is accepted when grant_valid & ready; beats increments.
// - beat_last = grant_valid & ready & (beats == quantum[owner]).
// - Release on: (a) accepted beat with beat_last, or (b) req[owner]==0.
// - On release: ptr <= owner+1 (wrap). Same cycle, re-pick from owner+1 with req excluding owner on case (b).
//   On case (a), owner is considered last.
//   - If a winner exists: owner <= winner, beats <= 0, stay GRANT (no idle cycle).
//   - Else: go IDLE.
// - Quantum sampling: quantum[owner] is sampled every cycle (not latched). A lowered value at or below beats releases on the next accepted beat.
// - beats width QW+1; never exceeds quantum+1.
// - Simultaneous: req[owner] drop with ready=1 counts no beat (grant_valid=0). ready with no owner is ignored.
// - Single requester with continuous req: re-granted to itself after each quantum, with no bubble.
// CONFIGURATION
// - ARB_PRIORITY_EN defined:
//   - Adds hi_pri port.
//   - Pick searches requesters with req&hi_pri first (round-robin from ptr); only if none, searches req&~hi_pri.
//   - A single shared ptr is used for both classes.
//   - A low-priority owner is not preempted mid-quantum.
// - ARB_PRIORITY_EN undefined: hi_pri port absent; single-class round-robin as above.
// STRUCTURE
// - Package gpu_arb_pkg:
//   - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t
//   - function rr_wrap_inc(idx, width)
// - Sub-module rr_pick #(WIDTH):
//   - Combinational rotate-and-find-first.
//   - Inputs: vec, start. Outputs: idx, found.
//   - Instantiated twice when ARB_PRIORITY_EN is defined.
// - Top level: FSM, ptr/owner/beats registers, release logic.
// TESTING
// - Reset: hold reset=0 with req=all ones -> grant_valid=0, empty=1, grant_oh=0; release reset -> grant=0 valid one cycle after.
// - Quantum:
//   - Stimulus: req=16'h0005, quantum[0]=2, quantum[2]=0, ready=1.
//   - Required: owner 0 for 3 beats, then owner 2 for 1 beat, then owner 0; beat_last on 3rd and 4th beats.
// - Backpressure: owner 3, quantum=1, ready toggles 1,0,0,1 -> exactly 2 accepted beats, then rotate; beats does not count ready=0 cycles.
// - Early release: owner 5 drops req after 1 of 4 beats while req[9]=1 -> next cycle grant=9, no IDLE cycle.
// - Wrap: req={15,1}, ptr starting at 15 -> grants 15, 1, 15; ptr wraps cleanly 15->0.
// - ARB_PRIORITY_EN: req=16'h0103, hi_pri=16'h0100 -> 8 wins every arbitration; 0,1 granted only after hi_pri cleared.
// - Reset mid-burst: assert reset at beat 2 of 4 -> next cycle all outputs at reset values; ptr=0.

Source files
------------

// File: rtl/gpu_arb_pkg.sv
// Shared types and helpers for the GPU issue-port arbiter.
package gpu_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // Increment an index and wrap back to zero after width-1.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned width);
    return (idx + 1 >= width) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_quantum_pick.sv
// rr_pick: combinational rotate-and-find-first. Scans vec starting at
// index start, wrapping modulo WIDTH, and returns the first set position.
module rr_pick #(
  parameter int WIDTH = 16,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [IDXW-1:0]  start,
  output logic [IDXW-1:0]  idx,
  output logic             found
);

  localparam logic [IDXW:0] WIDTHX = (IDXW+1)'(WIDTH);

  // Walk every position once from start, keeping the first hit.
  always_comb begin
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] pos;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum = {1'b0, start} + (IDXW+1)'(i);
      if (sum >= WIDTHX) sum = sum - WIDTHX;
      pos = sum[IDXW-1:0];
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_quantum.sv
// rr_arbiter_quantum: round-robin arbiter with a per-requester burst quantum.
// The owner keeps the grant for quantum[owner]+1 accepted beats, or until it
// drops its request, then the grant hands over with no idle cycle.
// Optional feature: define ARB_PRIORITY_EN to add the hi_pri port and a
// two-class pick (high-priority requesters searched first, shared pointer).
module rr_arbiter_quantum
  import gpu_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int QW    = 4,
  localparam int COUNTW = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    req,
  input  logic [WIDTH*QW-1:0] quantum,
  input  logic                ready,
`ifdef ARB_PRIORITY_EN
  input  logic [WIDTH-1:0]    hi_pri,
`endif
  output logic [COUNTW-1:0]   grant,
  output logic [WIDTH-1:0]    grant_oh,
  output logic                grant_valid,
  output logic                beat_last,
  output logic                empty
);

  arb_state_t        state, state_n;
  logic [COUNTW-1:0] ptr, ptr_n;
  logic [COUNTW-1:0] owner, owner_n;
  logic [QW:0]       beats, beats_n;

  logic [QW-1:0]     q_owner;
  logic [COUNTW-1:0] owner_inc;
  logic [COUNTW-1:0] pick_start;
  logic [COUNTW-1:0] win;
  logic              win_found;
  logic              accept;
  logic              release_now;

  assign owner_inc  = COUNTW'(rr_wrap_inc(32'(owner), WIDTH));
  // After a release the search starts just past the owner, so a finishing
  // owner that still requests is naturally considered last.
  assign pick_start = (state == ARB_GRANT) ? owner_inc : ptr;

`ifdef ARB_PRIORITY_EN
  logic [COUNTW-1:0] hi_idx, lo_idx;
  logic              hi_found, lo_found;

  rr_pick #(.WIDTH(WIDTH)) u_pick_hi (
    .vec   (req & hi_pri),
    .start (pick_start),
    .idx   (hi_idx),
    .found (hi_found)
  );

  rr_pick #(.WIDTH(WIDTH)) u_pick_lo (
    .vec   (req & ~hi_pri),
    .start (pick_start),
    .idx   (lo_idx),
    .found (lo_found)
  );

  assign win       = hi_found ? hi_idx : lo_idx;
  assign win_found = hi_found | lo_found;
`else
  rr_pick #(.WIDTH(WIDTH)) u_pick (
    .vec   (req),
    .start (pick_start),
    .idx   (win),
    .found (win_found)
  );
`endif

  // Select the live quantum field of the current owner (sampled every cycle).
  always_comb begin
    q_owner = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (owner == COUNTW'(i)) q_owner = quantum[i*QW +: QW];
    end
  end

  // Handshake qualification and release detection. The >= compare lets a
  // quantum lowered below the running count release on the next beat.
  always_comb begin
    grant_valid = (state == ARB_GRANT) && req[owner];
    accept      = grant_valid && ready;
    beat_last   = accept && (beats >= {1'b0, q_owner});
    release_now = (state == ARB_GRANT) && (beat_last || !req[owner]);
  end

  // Owner index, one-hot view and empty flag.
  always_comb begin
    grant    = owner;
    empty    = !grant_valid;
    grant_oh = '0;
    if (grant_valid) grant_oh[owner] = 1'b1;
  end

  // Next-state logic: arbitrate from idle, count beats, hand over on release.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    beats_n = beats;
    case (state)
      ARB_IDLE: begin
        if (win_found) begin
          state_n = ARB_GRANT;
          owner_n = win;
          beats_n = '0;
        end
      end
      ARB_GRANT: begin
        if (release_now) begin
          ptr_n = owner_inc;
          if (win_found) begin
            owner_n = win;
            beats_n = '0;
          end else begin
            state_n = ARB_IDLE;
          end
        end else if (accept) begin
          beats_n = beats + (QW+1)'(1);
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      owner <= '0;
      beats <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      beats <= beats_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_quantum.sv
// Directed self-checking bench for rr_arbiter_quantum.
// Priority scenario is included when ARB_PRIORITY_EN is defined.
module tb_rr_arbiter_quantum;

  localparam int WIDTH = 16;
  localparam int QW    = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [WIDTH-1:0]    req;
  logic [WIDTH*QW-1:0] quantum;
  logic                ready;
`ifdef ARB_PRIORITY_EN
  logic [WIDTH-1:0]    hi_pri;
`endif
  logic [3:0]          grant;
  logic [WIDTH-1:0]    grant_oh;
  logic                grant_valid;
  logic                beat_last;
  logic                empty;

  int passed = 0;
  int total  = 0;

  rr_arbiter_quantum #(.WIDTH(WIDTH), .QW(QW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .quantum     (quantum),
    .ready       (ready),
`ifdef ARB_PRIORITY_EN
    .hi_pri      (hi_pri),
`endif
    .grant       (grant),
    .grant_oh    (grant_oh),
    .grant_valid (grant_valid),
    .beat_last   (beat_last),
    .empty       (empty)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] r, input logic rdy);
    req   = r;
    ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic doReset();
    reset   = 1'b0;
    quantum = '0;
`ifdef ARB_PRIORITY_EN
    hi_pri  = '0;
`endif
    applyStimulus('0, 1'b0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset held with every requester asking.
    reset   = 1'b0;
    quantum = '0;
`ifdef ARB_PRIORITY_EN
    hi_pri  = '0;
`endif
    applyStimulus(16'hffff, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", grant_valid, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_oh", grant_oh, 0);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_last", beat_last, 0);
    reset = 1'b1;
    #1;
    checkOutput("rst_rel_valid0", grant_valid, 0);
    tick();
    checkOutput("rst_rel_grant", grant, 0);
    checkOutput("rst_rel_valid", grant_valid, 1);
    checkOutput("rst_rel_oh", grant_oh, 16'h0001);

    // Quantum: owner 0 for three beats, owner 2 for one, back to 0.
    doReset();
    quantum[0*QW +: QW] = 4'd2;
    quantum[2*QW +: QW] = 4'd0;
    applyStimulus(16'h0005, 1'b1);
    checkOutput("q_idle_valid", grant_valid, 0);
    tick();
    checkOutput("q_b1_grant", grant, 0);
    checkOutput("q_b1_last", beat_last, 0);
    tick();
    checkOutput("q_b2_grant", grant, 0);
    checkOutput("q_b2_last", beat_last, 0);
    tick();
    checkOutput("q_b3_grant", grant, 0);
    checkOutput("q_b3_last", beat_last, 1);
    tick();
    checkOutput("q_b4_grant", grant, 2);
    checkOutput("q_b4_last", beat_last, 1);
    checkOutput("q_b4_valid", grant_valid, 1);
    tick();
    checkOutput("q_b5_grant", grant, 0);
    checkOutput("q_b5_last", beat_last, 0);

    // Backpressure: owner 3, quantum 1, ready 1,0,0,1 then rotate to 6.
    doReset();
    quantum[3*QW +: QW] = 4'd1;
    applyStimulus(16'h0048, 1'b1);
    tick();
    checkOutput("bp_c1_grant", grant, 3);
    checkOutput("bp_c1_last", beat_last, 0);
    tick();
    applyStimulus(16'h0048, 1'b0);
    checkOutput("bp_c2_valid", grant_valid, 1);
    checkOutput("bp_c2_last", beat_last, 0);
    tick();
    applyStimulus(16'h0048, 1'b0);
    checkOutput("bp_c3_last", beat_last, 0);
    tick();
    applyStimulus(16'h0048, 1'b1);
    checkOutput("bp_c4_grant", grant, 3);
    checkOutput("bp_c4_last", beat_last, 1);
    tick();
    checkOutput("bp_c5_grant", grant, 6);
    checkOutput("bp_c5_valid", grant_valid, 1);

    // Early release: owner 5 drops after one beat, 9 takes over directly.
    doReset();
    quantum[5*QW +: QW] = 4'd3;
    applyStimulus(16'h0220, 1'b1);
    tick();
    checkOutput("er_c1_grant", grant, 5);
    checkOutput("er_c1_valid", grant_valid, 1);
    tick();
    applyStimulus(16'h0200, 1'b1);
    checkOutput("er_c2_valid", grant_valid, 0);
    checkOutput("er_c2_empty", empty, 1);
    checkOutput("er_c2_last", beat_last, 0);
    tick();
    checkOutput("er_c3_grant", grant, 9);
    checkOutput("er_c3_valid", grant_valid, 1);
    checkOutput("er_c3_oh", grant_oh, 16'h0200);

    // Wrap: ptr lands on 15 after owner 14 leaves, then 15, 1, 15.
    doReset();
    applyStimulus(16'h4000, 1'b1);
    tick();
    checkOutput("wr_c1_grant", grant, 14);
    applyStimulus(16'h8002, 1'b1);
    checkOutput("wr_c1_valid", grant_valid, 0);
    tick();
    checkOutput("wr_c2_grant", grant, 15);
    checkOutput("wr_c2_last", beat_last, 1);
    tick();
    checkOutput("wr_c3_grant", grant, 1);
    checkOutput("wr_c3_valid", grant_valid, 1);
    tick();
    checkOutput("wr_c4_grant", grant, 15);

    // Reset mid-burst: owner 5 at beat 2 of 4; pointer must return to 0.
    doReset();
    quantum[5*QW +: QW] = 4'd3;
    applyStimulus(16'h0021, 1'b1);
    tick();
    checkOutput("mb_c1_grant", grant, 0);
    checkOutput("mb_c1_last", beat_last, 1);
    tick();
    checkOutput("mb_c2_grant", grant, 5);
    checkOutput("mb_c2_last", beat_last, 0);
    tick();
    checkOutput("mb_c3_grant", grant, 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checkOutput("mb_rst_valid", grant_valid, 0);
    checkOutput("mb_rst_empty", empty, 1);
    checkOutput("mb_rst_oh", grant_oh, 0);
    checkOutput("mb_rst_grant", grant, 0);
    checkOutput("mb_rst_last", beat_last, 0);
    tick();
    checkOutput("mb_ptr0_grant", grant, 0);
    checkOutput("mb_ptr0_valid", grant_valid, 1);

`ifdef ARB_PRIORITY_EN
    // Priority: requester 8 wins while flagged, then 0 and 1 get turns.
    doReset();
    hi_pri = 16'h0100;
    applyStimulus(16'h0103, 1'b1);
    tick();
    checkOutput("hp_c1_grant", grant, 8);
    tick();
    checkOutput("hp_c2_grant", grant, 8);
    tick();
    checkOutput("hp_c3_grant", grant, 8);
    hi_pri = 16'h0000;
    tick();
    checkOutput("hp_c4_grant", grant, 0);
    tick();
    checkOutput("hp_c5_grant", grant, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
